// File: rtl/rgb_matrix_scanner.sv
// rtl/rgb_matrix_scanner.sv - double-buffered RGB LED matrix column scanner with PWM brightness
module rgb_matrix_scanner #(
  parameter int COLS      = 8,
  parameter int ROWS      = 8,
  parameter int DWELL_W   = 10,
  parameter int BLANK_CYC = 2,
  parameter int BRIGHT_W  = 3
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic [BRIGHT_W-1:0]       i_bright,
  input  logic                      i_wr_en,
  input  logic [$clog2(COLS)-1:0]   i_wr_col,
  input  logic [3*ROWS-1:0]         i_wr_rgb,
  input  logic                      i_swap_req,
  output logic                      o_swap_ack,
  output logic                      o_frame_done,
  output logic [COLS-1:0]           o_matriz_col,
  output logic [ROWS-1:0]           o_matriz_r,
  output logic [ROWS-1:0]           o_matriz_g,
  output logic [ROWS-1:0]           o_matriz_b
);

  localparam int COL_W = $clog2(COLS);
  localparam int BLK_W = $clog2(BLANK_CYC + 1);
  localparam int PIX_W = 3 * ROWS;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t             r_state;
  logic [COL_W-1:0]   r_col;
  logic [BLK_W-1:0]   r_blank_cnt;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_sel;
  logic               r_pending;
  logic [PIX_W-1:0]   r_bank0 [COLS];
  logic [PIX_W-1:0]   r_bank1 [COLS];

  logic                w_dwell_end;
  logic                w_last_col;
  logic                w_wrap;
  logic                w_swap;
  logic                w_lit;
  logic                w_wr_ok;
  logic [BRIGHT_W-1:0] w_duty;
  logic [PIX_W-1:0]    w_front;

  assign w_dwell_end = (r_state == S_SHOW) && (r_dwell == '1);
  assign w_last_col  = (r_col == COL_W'(COLS - 1));
  assign w_wrap      = i_enable && w_dwell_end && w_last_col;
  // An idle scanner has no frame to protect, so a pending swap goes through at once.
  assign w_swap      = (r_pending || i_swap_req) && ((r_state == S_IDLE) || w_wrap);
  assign w_duty      = r_dwell[DWELL_W-1 -: BRIGHT_W];
  assign w_lit       = (r_state == S_SHOW) && (w_duty < i_bright);
  assign w_front     = r_sel ? r_bank1[r_col] : r_bank0[r_col];
  assign w_wr_ok     = i_wr_en && (32'(i_wr_col) < COLS);

  // Scan FSM, swap bookkeeping and registered pin drive.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_blank_cnt  <= '0;
      r_dwell      <= '0;
      r_sel        <= 1'b0;
      r_pending    <= 1'b0;
      o_swap_ack   <= 1'b0;
      o_frame_done <= 1'b0;
      o_matriz_col <= '0;
      o_matriz_r   <= '1;
      o_matriz_g   <= '1;
      o_matriz_b   <= '1;
    end else begin
      o_swap_ack   <= w_swap;
      o_frame_done <= w_wrap;

      if (w_swap) begin
        r_sel     <= ~r_sel;
        r_pending <= 1'b0;
      end else if (i_swap_req) begin
        r_pending <= 1'b1;
      end

      if (!i_enable || !w_lit) begin
        o_matriz_col <= '0;
        o_matriz_r   <= '1;
        o_matriz_g   <= '1;
        o_matriz_b   <= '1;
      end else begin
        o_matriz_col <= COLS'(1) << r_col;
        o_matriz_r   <= ~w_front[3*ROWS-1 -: ROWS];
        o_matriz_g   <= ~w_front[2*ROWS-1 -: ROWS];
        o_matriz_b   <= ~w_front[ROWS-1:0];
      end

      if (!i_enable) begin
        r_state     <= S_IDLE;
        r_col       <= '0;
        r_blank_cnt <= '0;
        r_dwell     <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state     <= S_BLANK;
            r_col       <= '0;
            r_blank_cnt <= '0;
            r_dwell     <= '0;
          end
          S_BLANK: begin
            if (r_blank_cnt == BLK_W'(BLANK_CYC - 1)) begin
              r_state     <= S_SHOW;
              r_blank_cnt <= '0;
              r_dwell     <= '0;
            end else begin
              r_blank_cnt <= r_blank_cnt + BLK_W'(1);
            end
          end
          S_SHOW: begin
            r_dwell <= r_dwell + DWELL_W'(1);
            if (w_dwell_end) begin
              r_state <= S_BLANK;
              r_col   <= w_last_col ? '0 : r_col + COL_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Pixel writes always target the back bank as seen before this edge's swap.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < COLS; i++) begin
        r_bank0[i] <= '0;
        r_bank1[i] <= '0;
      end
    end else if (w_wr_ok) begin
      if (r_sel) begin
        r_bank0[i_wr_col] <= i_wr_rgb;
      end else begin
        r_bank1[i_wr_col] <= i_wr_rgb;
      end
    end
  end

endmodule

// File: tb/tb_rgb_matrix_scanner.sv
// tb/tb_rgb_matrix_scanner.sv - self-checking bench for rgb_matrix_scanner
module tb_rgb_matrix_scanner;
  localparam int COLS      = 8;
  localparam int ROWS      = 8;
  localparam int DWELL_W   = 3;
  localparam int BLANK_CYC = 1;
  localparam int BRIGHT_W  = 3;
  localparam int PERIOD    = BLANK_CYC + (1 << DWELL_W);
  localparam int FRAME     = COLS * PERIOD;

  logic        clk = 1'b0;
  logic        reset, enable, wr_en, swap_req;
  logic [2:0]  bright, wr_col;
  logic [23:0] wr_rgb;
  logic        swap_ack, frame_done;
  logic [7:0]  mcol, mr, mg, mb;

  always #5 clk = ~clk;

  rgb_matrix_scanner #(
    .COLS(COLS), .ROWS(ROWS), .DWELL_W(DWELL_W), .BLANK_CYC(BLANK_CYC), .BRIGHT_W(BRIGHT_W)
  ) dut (
    .i_clock(clk), .i_reset(reset), .i_enable(enable), .i_bright(bright),
    .i_wr_en(wr_en), .i_wr_col(wr_col), .i_wr_rgb(wr_rgb), .i_swap_req(swap_req),
    .o_swap_ack(swap_ack), .o_frame_done(frame_done), .o_matriz_col(mcol),
    .o_matriz_r(mr), .o_matriz_g(mg), .o_matriz_b(mb)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: frame position as a single counter, two banks, select and pending flag.
  logic [23:0] m_bank [2][COLS];
  int   m_sel, m_pend, m_scan, m_p;
  logic [7:0] e_col, e_r, e_g, e_b;
  logic e_ack, e_fd;

  task automatic model_step();
    int col, off;
    bit lit, wrap, swp;
    logic [23:0] px;
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < COLS; c++) m_bank[b][c] = '0;
      m_sel = 0; m_pend = 0; m_scan = 0; m_p = 0;
      e_col = 8'h00; e_r = 8'hFF; e_g = 8'hFF; e_b = 8'hFF; e_ack = 0; e_fd = 0;
      return;
    end
    col  = m_p / PERIOD;
    off  = m_p % PERIOD;
    lit  = enable && (m_scan != 0) && (off >= BLANK_CYC) &&
           (((off - BLANK_CYC) >> (DWELL_W - BRIGHT_W)) < int'(bright));
    px   = m_bank[m_sel][col];
    e_col = lit ? 8'(1 << col) : 8'h00;
    e_r   = lit ? ~px[23:16] : 8'hFF;
    e_g   = lit ? ~px[15:8]  : 8'hFF;
    e_b   = lit ? ~px[7:0]   : 8'hFF;
    wrap  = enable && (m_scan != 0) && (m_p == FRAME - 1);
    swp   = ((m_pend != 0) || swap_req) && ((m_scan == 0) || wrap);
    e_ack = swp;
    e_fd  = wrap;
    if (wr_en && int'(wr_col) < COLS) m_bank[1 - m_sel][wr_col] = wr_rgb;
    if (swp) begin
      m_sel  = 1 - m_sel;
      m_pend = 0;
    end else if (swap_req) begin
      m_pend = 1;
    end
    if (!enable) begin
      m_scan = 0; m_p = 0;
    end else if (m_scan == 0) begin
      m_scan = 1; m_p = 0;
    end else begin
      m_p = (m_p + 1) % FRAME;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    checks++;
    if ({mcol, mr, mg, mb, swap_ack, frame_done} !== {e_col, e_r, e_g, e_b, e_ack, e_fd}) begin
      errors++;
      $display("FAIL model cyc=%0d: got col=%h r=%h g=%h b=%h ack=%b fd=%b want col=%h r=%h g=%h b=%h ack=%b fd=%b",
               cyc, mcol, mr, mg, mb, swap_ack, frame_done, e_col, e_r, e_g, e_b, e_ack, e_fd);
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 0; swap_req = 0; wr_col = '0; wr_rgb = '0;
  endtask

  typedef struct {
    logic rst, en; logic [2:0] br; logic we; logic [2:0] wc; logic [23:0] wd; logic sr;
    logic [7:0] xcol, xr; logic xack, xfd;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int n, n2, ack_c, fd_c, bad;
    reset = 1; enable = 0; bright = 0; idle_inputs();

    tbl[0] = '{1, 0, 0, 0, 0, 24'h0, 0, 8'h00, 8'hFF, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 24'h0, 0, 8'h00, 8'hFF, 0, 0};
    tbl[2] = '{0, 0, 7, 1, 2, 24'h810000, 1, 8'h00, 8'hFF, 1, 0};
    tbl[3] = '{0, 1, 7, 0, 0, 24'h0, 0, 8'h00, 8'hFF, 0, 0};
    tbl[4] = '{0, 1, 7, 0, 0, 24'h0, 0, 8'h00, 8'hFF, 0, 0};
    tbl[5] = '{0, 1, 7, 0, 0, 24'h0, 0, 8'h01, 8'hFF, 0, 0};
    tbl[6] = '{0, 1, 7, 0, 0, 24'h0, 0, 8'h01, 8'hFF, 0, 0};

    for (int i = 0; i < 7; i++) begin
      reset = tbl[i].rst; enable = tbl[i].en; bright = tbl[i].br; wr_en = tbl[i].we;
      wr_col = tbl[i].wc; wr_rgb = tbl[i].wd; swap_req = tbl[i].sr;
      step();
      checks++;
      if ({mcol, mr, swap_ack, frame_done} !== {tbl[i].xcol, tbl[i].xr, tbl[i].xack, tbl[i].xfd}) begin
        errors++;
        $display("FAIL vec%0d: got col=%h r=%h ack=%b fd=%b want col=%h r=%h ack=%b fd=%b",
                 i, mcol, mr, swap_ack, frame_done, tbl[i].xcol, tbl[i].xr, tbl[i].xack, tbl[i].xfd);
      end
    end
    idle_inputs();

    // Column 2 shows the written red pattern for 7 of 8 show clocks.
    n = 0; n2 = 0; fd_c = 0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (mcol == 8'h04) n++;
      if (mcol == 8'h04 && mr == 8'h7E && mg == 8'hFF && mb == 8'hFF) n2++;
      if (frame_done) fd_c++;
    end
    check("col2_lit", n, 7);
    check("col2_data", n2, 7);
    check("frame_done_per_frame", fd_c, 1);

    // Brightness 3: 3 of 8 per column; brightness 0: dark.
    bright = 3;
    n = 0; n2 = 0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (mcol != 0) n++;
      if (mcol == 8'h01) n2++;
    end
    check("bright3_total", n, 24);
    check("bright3_col0", n2, 3);
    bright = 0;
    n = 0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (mcol != 0) n++;
    end
    check("bright0_dark", n, 0);

    // Swap requested during column 3 with a col 0 write: takes effect at frame end.
    bright = 7;
    n = 0;
    while (n < 2 * FRAME && m_p / PERIOD != 3) begin step(); n++; end
    check("reach_col3", m_p / PERIOD, 3);
    swap_req = 1; wr_en = 1; wr_col = 0; wr_rgb = 24'h0F0000;
    step();
    idle_inputs();
    ack_c = -1; fd_c = -1; bad = 0; n = 0;
    while (n < 2 * FRAME && fd_c < 0) begin
      step(); n++;
      if (swap_ack && ack_c < 0) ack_c = cyc;
      if (frame_done) fd_c = cyc;
      if (mcol == 8'h01 && mr != 8'hFF) bad++;
    end
    check("swap_ack_with_frame_done", ack_c, fd_c);
    check("front_unchanged_midframe", bad, 0);
    n = 0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (mcol == 8'h01 && mr == 8'hF0) n++;
    end
    check("new_col0_shown", n, 7);

    // Disable during column 5 show, then restart from column 0 blank.
    n = 0;
    while (n < 2 * FRAME && !(m_p / PERIOD == 5 && m_p % PERIOD >= BLANK_CYC + 2)) begin step(); n++; end
    check("reach_col5_show", m_p / PERIOD, 5);
    enable = 0;
    step();
    check("disable_blank_col", mcol, 0);
    check("disable_blank_r", mr, 8'hFF);
    step();
    enable = 1;
    step();
    check("reen_idle_blank", mcol, 0);
    step();
    check("reen_blank_phase", mcol, 0);
    step();
    check("reen_col0_show", mcol, 8'h01);

    // Reset mid-show with a pending swap: no ack, buffers cleared.
    n = 0;
    while (n < 2 * FRAME && !(m_p / PERIOD == 2 && m_p % PERIOD >= BLANK_CYC + 1)) begin step(); n++; end
    swap_req = 1;
    step();
    swap_req = 0;
    reset = 1;
    step();
    check("reset_blank_col", mcol, 0);
    check("reset_no_ack", swap_ack, 0);
    reset = 0; enable = 0;
    n = 0;
    for (int k = 0; k < 3; k++) begin step(); if (swap_ack) n++; end
    check("pending_cleared", n, 0);
    enable = 1;
    n = 0; bad = 0;
    for (int k = 0; k < FRAME + 2; k++) begin
      step();
      if (mcol != 0) n++;
      if (mcol != 0 && (mr != 8'hFF || mg != 8'hFF || mb != 8'hFF)) bad++;
    end
    check("cleared_bank_lit", n, 56);
    check("cleared_bank_off", bad, 0);

    // Randomised traffic against the model.
    for (int k = 0; k < 2500; k++) begin
      reset    = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if ($urandom_range(0, 39) == 0) bright = 3'($urandom_range(0, 7));
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_col   = 3'($urandom_range(0, 7));
      wr_rgb   = 24'($urandom);
      swap_req = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
